// File: rtl/cfg_command_dispatcher.sv
// Configuration command dispatcher: turns accepted commands into parser write/read
// strobes, returns the read ack (or a synthesised timeout ack) upstream, and counts traffic.
module cfg_command_dispatcher #(
    parameter int RD_TIMEOUT = 8,
    parameter int MIN_GAP    = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [203:0] iv_command,
    input  logic         i_command_wr,
    output logic         o_command_ready,
    output logic [203:0] ov_wr_command,
    output logic         o_wr_command_wr,
    output logic [203:0] ov_rd_command,
    output logic         o_rd_command_wr,
    input  logic [203:0] iv_rd_command_ack,
    output logic [203:0] ov_ack,
    output logic         o_ack_valid,
    input  logic         i_ack_ready,
    output logic [15:0]  ov_wr_cnt,
    output logic [15:0]  ov_rd_cnt,
    output logic [15:0]  ov_err_cnt
);

    localparam int WAIT_W = $clog2(RD_TIMEOUT);
    localparam int GAP_W  = (MIN_GAP < 1) ? 1 : $clog2(MIN_GAP + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_TIMEOUT - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(MIN_GAP);

    localparam logic [3:0] TYPE_WRITE = 4'h1;
    localparam logic [3:0] TYPE_READ  = 4'h2;
    localparam logic [3:0] TYPE_ACK   = 4'h6;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        ACK_OUT,
        GAP
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [GAP_W-1:0]  gap_cnt;

    // The strobe cycle itself is the first GAP cycle, so GAP lasts MIN_GAP+1 cycles
    // and accepted writes end up 2+MIN_GAP cycles apart.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state           <= IDLE;
            wait_cnt        <= '0;
            gap_cnt         <= '0;
            o_command_ready <= 1'b1;
            ov_wr_command   <= '0;
            o_wr_command_wr <= 1'b0;
            ov_rd_command   <= '0;
            o_rd_command_wr <= 1'b0;
            ov_ack          <= '0;
            o_ack_valid     <= 1'b0;
            ov_wr_cnt       <= '0;
            ov_rd_cnt       <= '0;
            ov_err_cnt      <= '0;
        end else begin
            o_wr_command_wr <= 1'b0;
            o_rd_command_wr <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_command_wr && o_command_ready) begin
                        o_command_ready <= 1'b0;
                        case (iv_command[187:184])
                            TYPE_WRITE: begin
                                ov_wr_command   <= iv_command;
                                o_wr_command_wr <= 1'b1;
                                ov_wr_cnt       <= ov_wr_cnt + 16'd1;
                                gap_cnt         <= '0;
                                state           <= GAP;
                            end
                            TYPE_READ: begin
                                ov_rd_command   <= iv_command;
                                o_rd_command_wr <= 1'b1;
                                wait_cnt        <= '0;
                                state           <= RD_WAIT;
                            end
                            default: begin
                                ov_err_cnt <= ov_err_cnt + 16'd1;
                                gap_cnt    <= '0;
                                state      <= GAP;
                            end
                        endcase
                    end
                end
                RD_WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (iv_rd_command_ack[187:184] == TYPE_ACK) begin
                        ov_ack      <= iv_rd_command_ack;
                        ov_rd_cnt   <= ov_rd_cnt + 16'd1;
                        o_ack_valid <= 1'b1;
                        state       <= ACK_OUT;
                    end else if (wait_cnt == WAIT_LAST) begin
                        ov_ack      <= {8'h0, 8'h3, 4'hF, ov_rd_command[183:152], 152'h0};
                        ov_err_cnt  <= ov_err_cnt + 16'd1;
                        o_ack_valid <= 1'b1;
                        state       <= ACK_OUT;
                    end
                end
                ACK_OUT: begin
                    if (i_ack_ready) begin
                        o_ack_valid <= 1'b0;
                        gap_cnt     <= '0;
                        state       <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        o_command_ready <= 1'b1;
                        state           <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    o_command_ready <= 1'b1;
                    o_ack_valid     <= 1'b0;
                    state           <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cfg_command_dispatcher.sv
// Directed self-checking bench for cfg_command_dispatcher (RD_TIMEOUT=8, MIN_GAP=2).
module tb_cfg_command_dispatcher;

    logic         i_clk;
    logic         i_rst_n;
    logic [203:0] iv_command;
    logic         i_command_wr;
    logic         o_command_ready;
    logic [203:0] ov_wr_command;
    logic         o_wr_command_wr;
    logic [203:0] ov_rd_command;
    logic         o_rd_command_wr;
    logic [203:0] iv_rd_command_ack;
    logic [203:0] ov_ack;
    logic         o_ack_valid;
    logic         i_ack_ready;
    logic [15:0]  ov_wr_cnt;
    logic [15:0]  ov_rd_cnt;
    logic [15:0]  ov_err_cnt;

    int testsRun;
    int testsFailed;
    logic [203:0] cmdWord;
    logic [203:0] ackWord;
    logic [203:0] expAck;

    cfg_command_dispatcher #(.RD_TIMEOUT(8), .MIN_GAP(2)) dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .iv_command       (iv_command),
        .i_command_wr     (i_command_wr),
        .o_command_ready  (o_command_ready),
        .ov_wr_command    (ov_wr_command),
        .o_wr_command_wr  (o_wr_command_wr),
        .ov_rd_command    (ov_rd_command),
        .o_rd_command_wr  (o_rd_command_wr),
        .iv_rd_command_ack(iv_rd_command_ack),
        .ov_ack           (ov_ack),
        .o_ack_valid      (o_ack_valid),
        .i_ack_ready      (i_ack_ready),
        .ov_wr_cnt        (ov_wr_cnt),
        .ov_rd_cnt        (ov_rd_cnt),
        .ov_err_cnt       (ov_err_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [203:0] makeCmd(input logic [7:0] target, input logic [3:0] kind,
                                             input logic [31:0] addr, input logic [151:0] data);
        return {8'h0, target, kind, addr, data};
    endfunction

    task automatic checkOutput(input string tag, input logic [203:0] actual, input logic [203:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [203:0] cmd, input logic wr);
        iv_command   = cmd;
        i_command_wr = wr;
    endtask

    task automatic nextCycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic waitReady(input string tag);
        for (int i = 0; i < 20 && !o_command_ready; i++) nextCycle();
        checkOutput(tag, {203'h0, o_command_ready}, 204'h1);
    endtask

    initial begin
        testsRun          = 0;
        testsFailed       = 0;
        i_rst_n           = 1'b0;
        i_ack_ready       = 1'b1;
        iv_rd_command_ack = '0;
        applyStimulus('0, 1'b0);
        repeat (3) @(posedge i_clk);
        #1;

        checkOutput("rst_ready", {203'h0, o_command_ready}, 204'h1);
        checkOutput("rst_strobes", {202'h0, o_wr_command_wr, o_rd_command_wr}, 204'h0);
        checkOutput("rst_ack_valid", {203'h0, o_ack_valid}, 204'h0);
        checkOutput("rst_ack", ov_ack, 204'h0);
        checkOutput("rst_cmds", ov_wr_command | ov_rd_command, 204'h0);
        checkOutput("rst_cnts", {156'h0, ov_wr_cnt, ov_rd_cnt, ov_err_cnt}, 204'h0);
        i_rst_n = 1'b1;
        nextCycle();

        // Single write: strobe at T+1 only, ready back at T+4
        cmdWord = makeCmd(8'h3, 4'h1, 32'h5, 152'hAB);
        applyStimulus(cmdWord, 1'b1);
        checkOutput("wr_ready_T", {203'h0, o_command_ready}, 204'h1);
        nextCycle();
        applyStimulus('0, 1'b0);
        checkOutput("wr_strobe_T1", {203'h0, o_wr_command_wr}, 204'h1);
        checkOutput("wr_word_T1", ov_wr_command, cmdWord);
        checkOutput("wr_ready_T1", {203'h0, o_command_ready}, 204'h0);
        checkOutput("wr_cnt_T1", {188'h0, ov_wr_cnt}, 204'h1);
        nextCycle();
        checkOutput("wr_strobe_T2", {203'h0, o_wr_command_wr}, 204'h0);
        checkOutput("wr_ready_T2", {203'h0, o_command_ready}, 204'h0);
        nextCycle();
        checkOutput("wr_ready_T3", {203'h0, o_command_ready}, 204'h0);
        nextCycle();
        checkOutput("wr_ready_T4", {203'h0, o_command_ready}, 204'h1);

        // Read with parser ack at T+2
        cmdWord = makeCmd(8'hc, 4'h2, 32'h10, 152'h0);
        ackWord = makeCmd(8'hc, 4'h6, 32'h10, 152'h1FF);
        applyStimulus(cmdWord, 1'b1);
        nextCycle();
        applyStimulus('0, 1'b0);
        checkOutput("rd_strobe_T1", {203'h0, o_rd_command_wr}, 204'h1);
        checkOutput("rd_word_T1", ov_rd_command, cmdWord);
        nextCycle();
        checkOutput("rd_strobe_T2", {203'h0, o_rd_command_wr}, 204'h0);
        iv_rd_command_ack = ackWord;
        nextCycle();
        iv_rd_command_ack = '0;
        checkOutput("rd_valid_T3", {203'h0, o_ack_valid}, 204'h1);
        checkOutput("rd_ackdata_T3", {195'h0, ov_ack[8:0]}, 204'h1FF);
        checkOutput("rd_ack_T3", ov_ack, ackWord);
        checkOutput("rd_cnt_T3", {188'h0, ov_rd_cnt}, 204'h1);
        nextCycle();
        checkOutput("rd_valid_T4", {203'h0, o_ack_valid}, 204'h0);
        waitReady("rd_ready_after");

        // Read with silent parser: timeout ack at T+1+RD_TIMEOUT
        cmdWord = makeCmd(8'h9, 4'h2, 32'hDEADBEEF, 152'h55);
        expAck  = {8'h0, 8'h3, 4'hF, 32'hDEADBEEF, 152'h0};
        applyStimulus(cmdWord, 1'b1);
        nextCycle();
        applyStimulus('0, 1'b0);
        for (int k = 1; k < 9; k++) begin
            checkOutput($sformatf("to_novalid_T%0d", k), {203'h0, o_ack_valid}, 204'h0);
            nextCycle();
        end
        checkOutput("to_valid_T9", {203'h0, o_ack_valid}, 204'h1);
        checkOutput("to_ack_T9", ov_ack, expAck);
        checkOutput("to_errcnt", {188'h0, ov_err_cnt}, 204'h1);
        checkOutput("to_rdcnt", {188'h0, ov_rd_cnt}, 204'h1);
        nextCycle();
        checkOutput("to_valid_T10", {203'h0, o_ack_valid}, 204'h0);
        waitReady("to_ready_after");

        // Read acked while upstream stalls for 10 cycles; commands pulsed meanwhile are ignored
        i_ack_ready = 1'b0;
        cmdWord = makeCmd(8'h1, 4'h2, 32'h20, 152'h0);
        ackWord = makeCmd(8'h1, 4'h6, 32'h20, 152'h3C3);
        applyStimulus(cmdWord, 1'b1);
        nextCycle();
        applyStimulus('0, 1'b0);
        nextCycle();
        iv_rd_command_ack = ackWord;
        nextCycle();
        iv_rd_command_ack = '0;
        for (int k = 0; k < 10; k++) begin
            checkOutput($sformatf("stall_valid_%0d", k), {203'h0, o_ack_valid}, 204'h1);
            checkOutput($sformatf("stall_ack_%0d", k), ov_ack, ackWord);
            checkOutput($sformatf("stall_nowr_%0d", k), {203'h0, o_wr_command_wr}, 204'h0);
            applyStimulus(makeCmd(8'h2, 4'h1, 32'h30, 152'h77), k[0]);
            nextCycle();
        end
        applyStimulus('0, 1'b0);
        checkOutput("stall_valid_end", {203'h0, o_ack_valid}, 204'h1);
        i_ack_ready = 1'b1;
        nextCycle();
        checkOutput("stall_valid_drop", {203'h0, o_ack_valid}, 204'h0);
        checkOutput("stall_wrcnt", {188'h0, ov_wr_cnt}, 204'h1);
        checkOutput("stall_rdcnt", {188'h0, ov_rd_cnt}, 204'h2);
        waitReady("stall_ready_after");

        // Unknown type 7 is dropped
        applyStimulus(makeCmd(8'h4, 4'h7, 32'h40, 152'h1), 1'b1);
        nextCycle();
        applyStimulus('0, 1'b0);
        checkOutput("drop_strobes", {202'h0, o_wr_command_wr, o_rd_command_wr}, 204'h0);
        checkOutput("drop_errcnt", {188'h0, ov_err_cnt}, 204'h2);
        waitReady("drop_ready_after");

        // Back-to-back writes held valid: one strobe every 4 cycles
        cmdWord = makeCmd(8'h5, 4'h1, 32'h50, 152'hBEEF);
        applyStimulus(cmdWord, 1'b1);
        for (int k = 1; k < 12; k++) begin
            nextCycle();
            checkOutput($sformatf("b2b_strobe_%0d", k), {203'h0, o_wr_command_wr},
                        {203'h0, (k % 4) == 1});
        end
        applyStimulus('0, 1'b0);
        checkOutput("b2b_wrcnt", {188'h0, ov_wr_cnt}, 204'h4);
        waitReady("b2b_ready_after");

        // Reset during RD_WAIT aborts the read
        applyStimulus(makeCmd(8'h6, 4'h2, 32'h60, 152'h0), 1'b1);
        nextCycle();
        applyStimulus('0, 1'b0);
        nextCycle();
        nextCycle();
        i_rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_ready", {203'h0, o_command_ready}, 204'h1);
        checkOutput("mid_rst_flags", {201'h0, o_wr_command_wr, o_rd_command_wr, o_ack_valid}, 204'h0);
        checkOutput("mid_rst_data", ov_ack | ov_wr_command | ov_rd_command, 204'h0);
        checkOutput("mid_rst_cnts", {156'h0, ov_wr_cnt, ov_rd_cnt, ov_err_cnt}, 204'h0);
        nextCycle();
        i_rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            nextCycle();
            checkOutput($sformatf("post_rst_noack_%0d", k), {203'h0, o_ack_valid}, 204'h0);
            checkOutput($sformatf("post_rst_ready_%0d", k), {203'h0, o_command_ready}, 204'h1);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
